// File: rtl/reg_scoreboard_pkg.sv
// Shared register-index and pending-counter definitions for the pipeline
// scoreboard, register file and hazard/forwarding logic.
package reg_scoreboard_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W    = 4;
    localparam int CNT_W    = 2;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/sb_counter.sv
// One saturating up/down pending-write counter; simultaneous inc and dec cancel.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             busy,
    output logic             ovf,
    output logic             udf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;

    always_comb begin
        count_d = count_q;
        ovf     = 1'b0;
        udf     = 1'b0;
        if (inc && !dec) begin
            if (count_q == CNT_MAX) ovf = 1'b1;
            else                    count_d = count_q + CNT_W'(1);
        end else if (dec && !inc) begin
            if (count_q == '0) udf = 1'b1;
            else               count_d = count_q - CNT_W'(1);
        end
        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign busy       = busy_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard: records ID-stage destinations, retires
// them at WB and stalls ID while any read source still has a write in flight.
module reg_scoreboard #(
    parameter int NUM_REGS  = reg_scoreboard_pkg::NUM_REGS,
    parameter int REG_W     = reg_scoreboard_pkg::REG_W,
    parameter int CNT_W     = reg_scoreboard_pkg::CNT_W,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   flush,
    input  logic                   issue_valid,
    input  logic                   issue_wb_en,
    input  logic [REG_W-1:0]       issue_dest,
    input  logic [REG_W-1:0]       src1,
    input  logic [REG_W-1:0]       src2,
    input  logic                   two_src,
    input  logic                   wb_valid,
    input  logic [REG_W-1:0]       wb_dest,
    output logic                   hazard_detected,
    output logic [NUM_REGS-1:0]    busy_mask,
    output logic [REG_W+CNT_W-1:0] inflight,
    output logic                   err_overflow,
    output logic                   err_underflow
);

    import reg_scoreboard_pkg::*;

    localparam int SUM_W = REG_W + CNT_W;

    logic [CNT_W-1:0]    cnt_q    [NUM_REGS];
    logic [CNT_W-1:0]    cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec, dec_vec, ovf_vec, udf_vec;
    logic                inc;
    logic                src1_pend, src2_pend;
    logic [SUM_W-1:0]    inflight_q, inflight_d;
    logic                err_overflow_q, err_overflow_d;
    logic                err_underflow_q, err_underflow_d;

    // A write-back committing this cycle retires one pending write of the
    // source, since the register file writes before it is read.
    function automatic logic src_pending(input logic [CNT_W-1:0] cnt,
                                         input logic              wb_hit);
        logic [CNT_W-1:0] eff;
        eff = cnt;
        if (WB_BYPASS && wb_hit && cnt != '0) eff = cnt - CNT_W'(1);
        return eff != '0;
    endfunction

    always_comb begin
        src1_pend = src_pending(cnt_q[src1], wb_valid && (wb_dest == src1));
        src2_pend = src_pending(cnt_q[src2], wb_valid && (wb_dest == src2));
        hazard_detected = issue_valid && (src1_pend || (two_src && src2_pend));
        inc = issue_valid && issue_wb_en && !hazard_detected && !freeze && !flush;
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign inc_vec[gi] = inc && (issue_dest == REG_W'(gi));
            assign dec_vec[gi] = wb_valid && (wb_dest == REG_W'(gi));

            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk        (clk),
                .rst        (rst),
                .inc        (inc_vec[gi]),
                .dec        (dec_vec[gi]),
                .count      (cnt_q[gi]),
                .count_next (cnt_next[gi]),
                .busy       (busy_mask[gi]),
                .ovf        (ovf_vec[gi]),
                .udf        (udf_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        inflight_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inflight_d = inflight_d + SUM_W'(cnt_next[i]);
        end
        err_overflow_d  = err_overflow_q  || (|ovf_vec);
        err_underflow_d = err_underflow_q || (|udf_vec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q      <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            inflight_q      <= inflight_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign inflight      = inflight_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard: a reference counter model
// pushes expected post-edge state, which is popped and checked after each edge.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, issue_valid, issue_wb_en, two_src, wb_valid;
    logic [3:0]  issue_dest, src1, src2, wb_dest;
    logic        hazard_detected, err_overflow, err_underflow;
    logic [15:0] busy_mask;
    logic [5:0]  inflight;

    reg_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .flush           (flush),
        .issue_valid     (issue_valid),
        .issue_wb_en     (issue_wb_en),
        .issue_dest      (issue_dest),
        .src1            (src1),
        .src2            (src2),
        .two_src         (two_src),
        .wb_valid        (wb_valid),
        .wb_dest         (wb_dest),
        .hazard_detected (hazard_detected),
        .busy_mask       (busy_mask),
        .inflight        (inflight),
        .err_overflow    (err_overflow),
        .err_underflow   (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] busy;
        logic [5:0]  infl;
        logic        ovf;
        logic        udf;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt [16];
    bit   m_ovf, m_udf;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_no = 0;

    function automatic bit m_pend(int s, bit wbv, int wbd);
        int e;
        e = m_cnt[s];
        if (wbv && wbd == s && e != 0) e = e - 1;
        return e != 0;
    endfunction

    task automatic check_post();
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (busy_mask === e.busy) else begin
            n_bad++;
            $error("FAIL step%0d busy_mask got=%h exp=%h", step_no, busy_mask, e.busy);
        end
        n_cmp++;
        assert (inflight === e.infl) else begin
            n_bad++;
            $error("FAIL step%0d inflight got=%0d exp=%0d", step_no, inflight, e.infl);
        end
        n_cmp++;
        assert (err_overflow === e.ovf) else begin
            n_bad++;
            $error("FAIL step%0d err_overflow got=%b exp=%b", step_no, err_overflow, e.ovf);
        end
        n_cmp++;
        assert (err_underflow === e.udf) else begin
            n_bad++;
            $error("FAIL step%0d err_underflow got=%b exp=%b", step_no, err_underflow, e.udf);
        end
    endtask

    task automatic push_model();
        exp_t e;
        e.busy = '0;
        e.infl = '0;
        for (int r = 0; r < 16; r++) begin
            if (m_cnt[r] != 0) e.busy[r] = 1'b1;
            e.infl = e.infl + 6'(m_cnt[r]);
        end
        e.ovf = m_ovf;
        e.udf = m_udf;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: drive, check hazard mid-cycle, advance model, check post-edge.
    task automatic step(input bit v, input bit we, input int d, input int s1,
                        input int s2, input bit two, input bit wbv, input int wbd,
                        input bit frz, input bit fl);
        bit exp_h, acc, i_r, d_r;
        step_no++;
        issue_valid = v; issue_wb_en = we; issue_dest = 4'(d);
        src1 = 4'(s1); src2 = 4'(s2); two_src = two;
        wb_valid = wbv; wb_dest = 4'(wbd); freeze = frz; flush = fl;
        #3;
        exp_h = v && (m_pend(s1, wbv, wbd) || (two && m_pend(s2, wbv, wbd)));
        n_cmp++;
        assert (hazard_detected === exp_h) else begin
            n_bad++;
            $error("FAIL step%0d hazard got=%b exp=%b", step_no, hazard_detected, exp_h);
        end
        acc = v && we && !exp_h && !frz && !fl;
        for (int r = 0; r < 16; r++) begin
            i_r = acc && (d == r);
            d_r = wbv && (wbd == r);
            if (i_r && !d_r) begin
                if (m_cnt[r] == 3) m_ovf = 1'b1;
                else m_cnt[r]++;
            end else if (d_r && !i_r) begin
                if (m_cnt[r] == 0) m_udf = 1'b1;
                else m_cnt[r]--;
            end
        end
        push_model();
        $display("step%0d v=%0b we=%0b d=%0d s1=%0d s2=%0d two=%0b wb=%0b/%0d frz=%0b fl=%0b haz=%0b",
                 step_no, v, we, d, s1, s2, two, wbv, wbd, frz, fl, hazard_detected);
        @(posedge clk);
        #1;
        check_post();
    endtask

    task automatic do_reset();
        step_no++;
        rst = 1'b1;
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        push_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("step%0d reset", step_no);
        check_post();
    endtask

    initial begin
        rst = 1'b1; freeze = 0; flush = 0; issue_valid = 0; issue_wb_en = 0;
        issue_dest = 0; src1 = 0; src2 = 0; two_src = 0; wb_valid = 0; wb_dest = 0;
        for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        m_ovf = 0; m_udf = 0;
        @(posedge clk);
        #1;
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);          // idle after reset
        // back-to-back dependence on r3 with bypass at WB
        step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8, 3, 0, 0, 0, 0, 0, 0);          // stalls, dest 8 not recorded
        step(1, 1, 8, 3, 0, 0, 0, 0, 0, 0);
        step(1, 1, 8, 3, 0, 0, 1, 3, 0, 0);          // bypass clears, dest 8 recorded
        step(0, 0, 0, 0, 0, 0, 1, 8, 0, 0);
        // self-dependence: dest==src1 with r1 free
        step(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        // two_src gating on r5
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        // simultaneous inc/dec on r7
        step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 1, 7, 0, 0);
        // saturation on r2, underflow on r9
        step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        // freeze and flush block issue, not retire
        step(1, 1, 4, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 4, 0, 0, 0, 1, 2, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        // build busy_mask 00F0 then reset mid-operation
        step(0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 6, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        assert (busy_mask === 16'h00F0) else begin
            n_bad++;
            $error("FAIL pre_reset busy_mask got=%h exp=%h", busy_mask, 16'h00F0);
        end
        do_reset();
        step(1, 0, 0, 4, 6, 1, 0, 0, 0, 0);          // no hazard after reset
        step(1, 1, 4, 4, 0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench timed out");
    end

endmodule
